fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the synchronous fifo among NUM_REQ requesters.
- Grants one requester at a time and holds that grant for a burst of up to MAX_BURST words.
- Muxes the owner's data onto the FIFO write interface and honours fifo_full as backpressure.
- Sits directly in front of the fifo write side; the read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// A grant holds for up to MAX_BURST accepted words; fifo_full stalls the burst.

module fifo_wr_arbiter_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  gnt,
    input  logic                  req,
    input  logic                  fifo_full,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] data_masked
);
    // gnt is one-hot, so OR-ing the masked lanes forms the owner mux
    assign ack         = gnt & req & ~fifo_full;
    assign data_masked = data & {DATA_WIDTH{gnt}};
endmodule

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);
    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                                state, state_n;
    logic [OWN_W-1:0]                      owner_n, rr_ptr, rr_ptr_n, winner;
    logic [NUM_REQ-1:0]                    gnt_n;
    logic [CNT_W-1:0]                      burst_cnt, burst_cnt_n;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    data_arr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    lane_data;
    logic                                  last_word;

    assign data_arr  = req_data;
    assign last_word = (burst_cnt == CNT_W'(MAX_BURST - 1));

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        fifo_wr_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .gnt        (gnt[i]),
            .req        (req[i]),
            .fifo_full  (fifo_full),
            .data       (data_arr[i]),
            .ack        (ack[i]),
            .data_masked(lane_data[i])
        );
    end

    // Scan downward so the requester closest above rr_ptr is written last and wins
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ])
                winner = OWN_W'((int'(rr_ptr) + k) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            rr_ptr    <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            owner     <= owner_n;
            burst_cnt <= burst_cnt_n;
            rr_ptr    <= rr_ptr_n;
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        owner_n     = owner;
        burst_cnt_n = burst_cnt;
        rr_ptr_n    = rr_ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_n        = BUSY;
                    owner_n        = winner;
                    gnt_n          = '0;
                    gnt_n[winner]  = 1'b1;
                    burst_cnt_n    = '0;
                end
            end
            BUSY: begin
                if ((fifo_wr && last_word) || !req[owner]) begin
                    state_n     = IDLE;
                    gnt_n       = '0;
                    owner_n     = '0;
                    burst_cnt_n = '0;
                    rr_ptr_n    = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
                end else if (fifo_wr) begin
                    burst_cnt_n = burst_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs derive from gnt, so an async reset clears them without a clock
    always_comb begin
        busy         = (state == BUSY);
        fifo_wr      = |ack;
        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            fifo_wr_data = fifo_wr_data | lane_data[i];
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester traffic, expected
// write order queued at issue time and checked by an independent monitor.

module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              arst = 1'b1;
    logic [NR-1:0]     req, gnt, ack;
    logic [NR*DW-1:0]  req_data;
    logic              fifo_wr, fifo_full, busy;
    logic [DW-1:0]     fifo_wr_data;
    logic [1:0]        owner;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .arst(arst), .req(req), .req_data(req_data), .gnt(gnt),
        .ack(ack), .fifo_wr(fifo_wr), .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full), .busy(busy), .owner(owner)
    );

    typedef struct packed {
        logic [1:0]    who;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] rd_exp[$];
    logic [DW-1:0] rq[NR][$];
    logic [DW-1:0] fq[$];
    int            wr_log[$];
    int            checks = 0, errors = 0, cyc = 0, fcnt = 0;
    logic          full_force = 1'b0, use_fifo = 1'b0, rd_en = 1'b0;

    assign fifo_full = use_fifo ? (fcnt == 4) : full_force;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] word(input int tag, input int i, input int k);
        return DW'(tag << 16) | DW'(i << 8) | DW'(k);
    endfunction

    task automatic push_exp(input int who, input logic [DW-1:0] d);
        wr_t e;
        e.who  = 2'(who);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || rd_exp.size() > 0) && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, (exp_q.size() == 0 && rd_exp.size() == 0), 1);
    endtask

    task automatic wait_exp(input string name, input int left, input int budget);
        int n = 0;
        while (exp_q.size() > left && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, exp_q.size() <= left, 1);
    endtask

    // Requesters and the small FIFO model: sample at negedge, update after posedge
    initial begin
        logic [NR-1:0] a;
        logic          w, r;
        logic [DW-1:0] d;
        req = '0;
        req_data = '0;
        forever begin
            @(negedge clk);
            a = ack; w = fifo_wr; d = fifo_wr_data; r = rd_en && (fcnt > 0);
            @(posedge clk); #1;
            for (int i = 0; i < NR; i++) begin
                if (a[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req[i] = (rq[i].size() > 0);
                req_data[i*DW +: DW] = req[i] ? rq[i][0] : '0;
            end
            if (use_fifo) begin
                if (r) void'(fq.pop_front());
                if (w) fq.push_back(d);
                fcnt = fq.size();
            end
        end
    end

    // Monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (gnt != '0) chk("ack_vs_wr", |ack, fifo_wr);
            if (fifo_wr) begin
                chk("wr_while_full", fifo_full, 0);
                wr_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got %0h expected no write", fifo_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_data", fifo_wr_data, e.data);
                    chk("wr_owner", owner, e.who);
                    chk("wr_ack", ack, NR'(1) << e.who);
                end
            end
            if (use_fifo && rd_en && fq.size() > 0) begin
                if (rd_exp.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got %0h expected no read", fq[0]);
                end else chk("rd_data", fq[0], rd_exp.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk); #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_wr", fifo_wr, 0);
        chk("rst_ack", ack, 0);
        chk("rst_wdata", fifo_wr_data, 0);
        @(negedge clk); arst = 1'b0;

        // 1: lone requester 0, 6 words -> burst of 4, gap, burst of 2
        @(posedge clk); #2;
        wr_log.delete();
        for (int k = 0; k < 6; k++) begin
            rq[0].push_back(32'hA0 + k);
            push_exp(0, 32'hA0 + k);
        end
        @(negedge clk);
        @(negedge clk); #1;
        chk("t1_gnt_at_req", gnt, 4'b0000);
        @(negedge clk); #1;
        chk("t1_gnt_next", gnt, 4'b0001);
        chk("t1_busy", busy, 1);
        drain("t1_drain", 100);
        chk("t1_b2b", wr_log[3] - wr_log[0], 3);
        chk("t1_gap", wr_log[4] - wr_log[3], 2);
        chk("t1_b2b2", wr_log[5] - wr_log[4], 1);
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_gnt", gnt, 0);

        // 2: all four requesting; rr_ptr=1 after test 1 -> order 1,2,3,0,1,2,3,0
        @(posedge clk); #2;
        wr_log.delete();
        for (int i = 0; i < NR; i++)
            for (int k = 0; k < 8; k++) rq[i].push_back(word(16'hB0, i, k));
        for (int rnd = 0; rnd < 2; rnd++)
            for (int g = 1; g <= NR; g++)
                for (int k = 0; k < 4; k++)
                    push_exp(g % NR, word(16'hB0, g % NR, rnd * 4 + k));
        drain("t2_drain", 300);
        chk("t2_count", wr_log.size(), 32);
        chk("t2_span", wr_log[31] - wr_log[0], 38);
        chk("t2_gap", wr_log[4] - wr_log[3], 2);
        repeat (3) @(negedge clk);

        // 3: requester 2 stalled by full for 3 cycles after its 2nd word
        @(posedge clk); #2;
        wr_log.delete();
        for (int k = 0; k < 4; k++) begin
            rq[2].push_back(32'hC0 + k);
            push_exp(2, 32'hC0 + k);
        end
        wait_exp("t3_wait", 2, 50);
        @(posedge clk); #2; full_force = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); #1;
            chk("t3_stall_wr", fifo_wr, 0);
            chk("t3_stall_ack", ack, 0);
            chk("t3_stall_gnt", gnt, 4'b0100);
        end
        @(posedge clk); #2; full_force = 1'b0;
        drain("t3_drain", 50);
        chk("t3_count", wr_log.size(), 4);
        chk("t3_stall_gap", wr_log[2] - wr_log[1], 4);
        repeat (3) @(negedge clk);

        // 4: requester 1 withdraws after 2 words; req 3 wins next (rr_ptr=2)
        @(posedge clk); #2;
        wr_log.delete();
        rq[1].push_back(32'hD0); rq[1].push_back(32'hD1);
        push_exp(1, 32'hD0); push_exp(1, 32'hD1);
        wait_exp("t4_wait", 1, 50);
        chk("t4_gnt1", gnt, 4'b0010);
        @(posedge clk); #2;
        for (int k = 0; k < 5; k++) begin
            rq[3].push_back(32'hE0 + k);
            push_exp(3, 32'hE0 + k);
        end
        drain("t4_drain", 100);
        chk("t4_count", wr_log.size(), 7);
        chk("t4_drop_gap", wr_log[2] - wr_log[1], 3);
        chk("t4_full_burst", wr_log[5] - wr_log[2], 3);
        chk("t4_regrant", wr_log[6] - wr_log[5], 2);
        repeat (3) @(negedge clk);

        // 5: async reset mid-burst of requester 3
        @(posedge clk); #2;
        for (int k = 0; k < 4; k++) rq[3].push_back(32'hF0 + k);
        push_exp(3, 32'hF0); push_exp(3, 32'hF1);
        wait_exp("t5_wait", 0, 50);
        @(posedge clk); #2; full_force = 1'b1;
        @(posedge clk); #1;
        chk("t5_pre_busy", busy, 1);
        #2 arst = 1'b1;
        #1;
        chk("t5_rst_gnt", gnt, 0);
        chk("t5_rst_ack", ack, 0);
        chk("t5_rst_wr", fifo_wr, 0);
        chk("t5_rst_busy", busy, 0);
        full_force = 1'b0;
        rq[3].delete();
        repeat (2) @(negedge clk);
        arst = 1'b0;
        @(posedge clk); #2;
        for (int i = 0; i < NR; i++) begin
            rq[i].push_back(32'h60 + i);
            push_exp(i, 32'h60 + i);
        end
        drain("t5_drain", 100);
        repeat (3) @(negedge clk);

        // 6: depth-4 FIFO model, requesters 0..2 send 4 words each, reads start after stall
        @(posedge clk); #2;
        use_fifo = 1'b1;
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++) begin
                rq[i].push_back(word(16'h70, i, k));
                push_exp(i, word(16'h70, i, k));
                rd_exp.push_back(word(16'h70, i, k));
            end
        begin
            int n = 0;
            while (fcnt != 4 && n < 50) begin @(negedge clk); #1; n++; end
            chk("t6_full", fcnt, 4);
        end
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); #1;
            chk("t6_stall_wr", fifo_wr, 0);
            chk("t6_stall_gnt", gnt, 4'b0010);
        end
        @(posedge clk); #2; rd_en = 1'b1;
        drain("t6_drain", 200);
        rd_en = 1'b0;
        @(posedge clk); #2;
        chk("t6_empty", fcnt, 0);
        use_fifo = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
